// File: rtl/sd_mod_decim_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_mod_decim_if
// Brief    : Sample/enable inputs and decimated-result outputs of sd_mod_decim.
// Revision : 1.0 - initial release
// ============================================================================
interface sd_mod_decim_if #(
    parameter int DATA_W   = 24,
    parameter int CHANNELS = 1,
    parameter int OUT_W    = 7
);
    logic                         en;
    logic [CHANNELS*DATA_W-1:0]   analog_in;
    logic [CHANNELS-1:0]          sd_bit;
    logic [CHANNELS*OUT_W-1:0]    out_data;
    logic                         out_valid;

    modport master (
        output en,
        output analog_in,
        input  sd_bit,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  en,
        input  analog_in,
        output sd_bit,
        output out_data,
        output out_valid
    );
endinterface
`default_nettype wire

// File: rtl/sd_mod_decim.sv
`default_nettype none
// ============================================================================
// Module   : sd_mod_decim
// Brief    : Multi-channel first-order sigma-delta modulator with sinc1/sinc2
//            decimation by OSR.
// Revision : 1.0 - initial release
// ============================================================================
module sd_mod_decim #(
    parameter int DATA_W   = 24,
    parameter int OSR      = 64,
    parameter int CHANNELS = 1,
    parameter int ORDER    = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    sd_mod_decim_if.slave     bus
);
    localparam int LOG_OSR = $clog2(OSR);
    localparam int OUT_W   = ORDER * LOG_OSR + 1;
    localparam logic [LOG_OSR-1:0] C_LAST = LOG_OSR'(OSR - 1);

    logic [LOG_OSR-1:0]         r_cnt;
    logic                       r_out_valid;
    logic                       w_decim;
    logic [CHANNELS-1:0]        w_sd_bit;
    logic [CHANNELS*OUT_W-1:0]  w_out_data;

    generate
        if ((OSR < 4) || (OSR > 1024) || ((1 << LOG_OSR) != OSR)) begin : g_bad_osr
            $error("sd_mod_decim: OSR must be a power of two in 4..1024");
        end
    endgenerate

    assign w_decim = bus.en && (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // Valid drops on held cycles so it is never more than one cycle wide.
            r_out_valid <= w_decim;
            if (bus.en) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            logic [DATA_W-1:0] w_x;
            logic [DATA_W:0]   w_sum;
            logic [DATA_W-1:0] r_acc;
            logic              r_bit;
            logic              w_b;

            assign w_x   = bus.analog_in[c*DATA_W +: DATA_W];
            assign w_sum = {1'b0, r_acc} + {1'b0, w_x};
            assign w_b   = w_sum[DATA_W];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_acc <= '0;
                    r_bit <= 1'b0;
                end else if (bus.en) begin
                    r_acc <= w_sum[DATA_W-1:0];
                    r_bit <= w_b;
                end
            end

            assign w_sd_bit[c] = r_bit;

            if (ORDER == 1) begin : g_sinc1
                logic [OUT_W-1:0] r_ones;
                logic [OUT_W-1:0] r_out;
                logic [OUT_W-1:0] w_ones_n;

                // The bit from the decimation edge itself belongs to the frame.
                assign w_ones_n = r_ones + OUT_W'(w_b);

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_ones <= '0;
                        r_out  <= '0;
                    end else if (bus.en) begin
                        if (w_decim) begin
                            r_out  <= w_ones_n;
                            r_ones <= '0;
                        end else begin
                            r_ones <= w_ones_n;
                        end
                    end
                end

                assign w_out_data[c*OUT_W +: OUT_W] = r_out;
            end else if (ORDER == 2) begin : g_sinc2
                logic [OUT_W-1:0] r_i1, r_i2, r_d1, r_c1, r_out;
                logic [OUT_W-1:0] w_i1n, w_i2n, w_c1n;

                // Modulo-2^OUT_W wrap in the integrators cancels in the combs.
                assign w_i1n = r_i1 + OUT_W'(w_b);
                assign w_i2n = r_i2 + w_i1n;
                assign w_c1n = w_i2n - r_d1;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_i1  <= '0;
                        r_i2  <= '0;
                        r_d1  <= '0;
                        r_c1  <= '0;
                        r_out <= '0;
                    end else if (bus.en) begin
                        r_i1 <= w_i1n;
                        r_i2 <= w_i2n;
                        if (w_decim) begin
                            r_d1  <= w_i2n;
                            r_c1  <= w_c1n;
                            r_out <= w_c1n - r_c1;
                        end
                    end
                end

                assign w_out_data[c*OUT_W +: OUT_W] = r_out;
            end else begin : g_bad_order
                $error("sd_mod_decim: ORDER must be 1 or 2");
            end
        end
    endgenerate

    assign bus.sd_bit    = w_sd_bit;
    assign bus.out_data  = w_out_data;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_sd_mod_decim.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_mod_decim
// Brief    : Directed bench: five-channel sinc1 and two-channel sinc2 instances
//            run in lockstep on shared clock, reset and enable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_mod_decim;
    localparam int W1 = 7;   // ORDER=1, OSR=64
    localparam int W2 = 13;  // ORDER=2, OSR=64

    logic clk = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    sd_mod_decim_if #(.DATA_W(24), .CHANNELS(5), .OUT_W(W1)) if1 ();
    sd_mod_decim_if #(.DATA_W(24), .CHANNELS(2), .OUT_W(W2)) if2 ();

    sd_mod_decim #(.DATA_W(24), .OSR(64), .CHANNELS(5), .ORDER(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1)
    );
    sd_mod_decim #(.DATA_W(24), .OSR(64), .CHANNELS(2), .ORDER(2)) dut2 (
        .clk(clk), .reset(reset), .bus(if2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_en(input logic v);
        if1.en = v;
        if2.en = v;
    endtask

    task automatic check_data(input string tag, input int e1 [5], input int e2 [2]);
        for (int c = 0; c < 5; c++)
            check($sformatf("%s o1 ch%0d", tag, c), 32'(if1.out_data[c*W1 +: W1]), 32'(e1[c]));
        for (int c = 0; c < 2; c++)
            check($sformatf("%s o2 ch%0d", tag, c), 32'(if2.out_data[c*W2 +: W2]), 32'(e2[c]));
    endtask

    task automatic check_valid(input string tag, input logic exp);
        check({tag, " valid1"}, 32'(if1.out_valid), 32'(exp));
        check({tag, " valid2"}, 32'(if2.out_valid), 32'(exp));
    endtask

    int zero1 [5] = '{0, 0, 0, 0, 0};
    int zero2 [2] = '{0, 0};
    int f1_1  [5] = '{0, 16, 32, 48, 63};
    int f1_2  [2] = '{1024, 2016};
    int ss_1  [5] = '{0, 16, 32, 48, 64};
    int ss_2  [2] = '{2048, 4096};

    initial begin
        logic [4:0] prev1;
        logic [1:0] prev2;

        reset = 1'b1;
        set_en(1'b1);
        if1.analog_in = {24'hFFFFFF, 24'hC00000, 24'h800000, 24'h400000, 24'h000000};
        if2.analog_in = {24'hFFFFFF, 24'h800000};
        repeat (3) tick();

        check_valid("reset", 1'b0);
        check("reset sd1", 32'(if1.sd_bit), 32'd0);
        check("reset sd2", 32'(if2.sd_bit), 32'd0);
        check_data("reset", zero1, zero2);

        // Frame 1 after release: first valid on the 64th edge.
        reset = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            check_valid($sformatf("f1 k%0d", k), 1'(k == 64));
            if (k <= 8) begin
                check($sformatf("f1 sd half k%0d", k), 32'(if1.sd_bit[2]), 32'(k % 2 == 0));
                check($sformatf("f1 sd zero k%0d", k), 32'(if1.sd_bit[0]), 32'd0);
                check($sformatf("f1 sd full k%0d", k), 32'(if1.sd_bit[4]), 32'(k > 1));
            end
        end
        check_data("f1", f1_1, f1_2);

        // Frame 2: exact 64-cycle spacing and settled values.
        for (int k = 1; k <= 64; k++) begin
            tick();
            check_valid($sformatf("f2 k%0d", k), 1'(k == 64));
        end
        check_data("f2", ss_1, ss_2);

        // Frame 3: results held between strobes, sinc2 still correct through wrap.
        for (int k = 1; k <= 64; k++) begin
            tick();
            check_valid($sformatf("f3 k%0d", k), 1'(k == 64));
            if (k == 1) check_data("f3 hold", ss_1, ss_2);
        end
        check_data("f3", ss_1, ss_2);

        // Frame 4 with en alternating low/high: 128-cycle spacing.
        for (int k = 1; k <= 128; k++) begin
            set_en(1'(k % 2 == 0));
            prev1 = if1.sd_bit;
            prev2 = if2.sd_bit;
            tick();
            check_valid($sformatf("en k%0d", k), 1'(k == 128));
            if (k % 2 == 1 && k < 16) begin
                check($sformatf("en hold sd1 k%0d", k), 32'(if1.sd_bit), 32'(prev1));
                check($sformatf("en hold sd2 k%0d", k), 32'(if2.sd_bit), 32'(prev2));
            end
        end
        check_data("en", ss_1, ss_2);
        set_en(1'b1);

        // Reset at cnt=40 for one cycle, then a clean first frame.
        repeat (40) tick();
        reset = 1'b1;
        tick();
        check_valid("midrst", 1'b0);
        check("midrst sd1", 32'(if1.sd_bit), 32'd0);
        check("midrst sd2", 32'(if2.sd_bit), 32'd0);
        check_data("midrst", zero1, zero2);
        reset = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            check_valid($sformatf("post k%0d", k), 1'(k == 64));
        end
        check_data("post", f1_1, f1_2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sd_mod_decim.md
# sd_mod_decim

Multi-channel first-order digital sigma-delta modulator with an integrated sinc^ORDER decimation filter. Each channel converts a DATA_W-bit unsigned sample into a 1-bit density stream. The block decimates that stream by OSR into an OUT_W-bit result with a one-cycle valid strobe. It sits between the sample source and the converter back end, and replaces the single-channel fixed-width oversampling stage.

## Interface
- DATA_W, 24: input sample width per channel (unsigned, full scale = 2^DATA_W).
- OSR, 64: oversampling/decimation ratio; power of two, 4..1024. LOG_OSR = log2(OSR).
- CHANNELS, 1: number of independent parallel channels, 1..8.
- ORDER, 1: decimator order, 1 (sinc1 accumulate-and-dump) or 2 (sinc2 CIC); any other value is a synthesis error.
- OUT_W, derived = ORDER*LOG_OSR+1: output width per channel.

- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- en  in  1  clock enable; when low, every register holds.
- analog_in  in  CHANNELS*DATA_W  packed samples; channel c = bits [c*DATA_W +: DATA_W].
- sd_bit  out  CHANNELS  registered modulator bitstream, one bit per channel.
- out_data  out  CHANNELS*OUT_W  decimated results, channel c = [c*OUT_W +: OUT_W]; held between strobes.
- out_valid  out  1  one-cycle pulse marking new out_data (all channels together).

## Operation
- Modulator, per channel, on each enabled edge:
  - sum = acc + x, computed DATA_W+1 bits wide.
  - sd_bit <= sum[DATA_W]; acc <= sum[DATA_W-1:0].
  - This is the exact carry-out form. The ones-density over time equals x/2^DATA_W.
  - x = 0 gives a constant 0. x = 2^DATA_W-1 gives all ones except the first cycle after reset.
- Frame counter cnt (LOG_OSR bits), shared by all channels.
  - Increments on each enabled edge and wraps OSR-1 -> 0.
  - The edge where cnt == OSR-1 is the decimation edge.
- ORDER=1, per channel:
  - ones counter `ones` (OUT_W bits); b = the bit produced on the current edge.
  - On a non-decimation edge: ones <= ones + b.
  - On the decimation edge: out_data_c <= ones + b and ones <= 0.
  - Result range is 0..OSR inclusive.
- ORDER=2, per channel:
  - Registers: i1, i2, d1, d2, c1, all OUT_W bits, modulo-2^OUT_W wraparound.
  - On every enabled edge: i1n = i1 + b; i2n = i2 + i1n; i1 <= i1n; i2 <= i2n.
  - On the decimation edge:
    - c1n = i2n - d1; d1 <= i2n.
    - out_data_c <= c1n - c1; c1 <= c1n.
  - Steady-state result range is 0..OSR^2.
- out_valid <= 1 on the decimation edge, 0 on every other edge. It is also 0 on any edge with en low.
- Reset value of every output: sd_bit = 0, out_data = 0, out_valid = 0.
- Reset clears all internal state to 0: acc, cnt, ones, i1, i2, d1, d2, c1.
- Reset mid-frame discards the partial frame. The frame count restarts from 0 after reset release.
- reset has priority over en.
- en low mid-frame pauses the frame. Counts resume where they stopped; held cycles contribute nothing.
- Channels are fully independent and share only cnt and out_valid.

## Timing
- sd_bit for sample x appears one cycle after the enabled edge that sampled x.
- The first out_valid is high in the cycle after the OSR-th enabled edge following reset release.
- Subsequent out_valid pulses arrive every OSR enabled edges. With en held high, the spacing is exactly OSR cycles.
- out_data updates on the same edge that raises out_valid and is stable until the next decimation edge.
- ORDER=2 results are settled from the second frame onward. The first frame after reset is a transient (a partial impulse response).
- No combinational path from any input to any output.

## Test plan
- DATA_W=24, OSR=64, ORDER=1, x=0x800000, en=1 continuous:
  - sd_bit alternates 0,1,0,1 starting with 0.
  - Every out_data = 32, with out_valid every 64 cycles.
  - First out_valid falls 64 cycles after reset release.
- ORDER=1 boundaries:
  - x=0: every frame = 0.
  - x=0xFFFFFF: frame 1 = 63, all later frames = 64. Confirms no wrap at 7 bits.
- ORDER=2, OSR=64, x=0x800000: frame 1 = 1024, frames 2+ = 2048. x=0xFFFFFF: steady state = 4096.
- CHANNELS=4 with x = 0, 0x400000, 0x800000, 0xC00000, ORDER=1: steady out_data = 0, 16, 32, 48 in the same out_valid strobe.
- en toggled 1,0 alternately with ORDER=1, x=0x800000: all registers hold on en=0 cycles. out_valid spacing is 128 cycles and values still = 32.
- Reset asserted at cnt=40, held 1 cycle:
  - Next edge gives out_valid=0 and out_data=0.
  - Next out_valid comes 64 enabled edges after release, and the value equals the value of a clean first frame.
